// File: rtl/register_file_sb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : register_file_sb
//  Description : Parametrised CPU register file with a per-register scoreboard.
//                Two combinational read ports (RS, RT) return data and busy
//                bits. One synchronous write port (RD) stores data and clears
//                the busy bit. The issue stage sets a busy bit through
//                Reserve/RsvAddr. Register 0 can be hardwired to zero.
//                Optional feature macro: REGFILE_BYPASS_EN. When it is defined,
//                a write in the current cycle is forwarded to the read ports.
//  Revision    : 1.0  initial release
// ============================================================================
module register_file_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] RS,
    input  logic [ADDR_W-1:0] RT,
    output logic [DATA_W-1:0] ReadRS,
    output logic [DATA_W-1:0] ReadRT,
    output logic              BusyRS,
    output logic              BusyRT,
    input  logic [ADDR_W-1:0] RD,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] RsvAddr
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam int                NUM_PORTS = 2;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

    // Architectural state
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;

    // Qualified requests. Address 0 is read-only when it is hardwired to zero.
    logic write_ok;
    logic reserve_ok;

    assign write_ok   = RegWrite && ((ZERO_REG == 0) || (RD != ZERO_ADDR));
    assign reserve_ok = Reserve  && ((ZERO_REG == 0) || (RsvAddr != ZERO_ADDR));

    // Scoreboard update: writeback clears first, so a same-address reserve wins
    always_comb begin
        busy_next = busy;
        if (write_ok) begin
            busy_next[RD] = 1'b0;
        end
        if (reserve_ok) begin
            busy_next[RsvAddr] = 1'b1;
        end
    end

    // Data storage: reset clears every register, otherwise accept qualified writes
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[RD] <= WriteData;
        end
    end

    // Busy-bit register: reset discards all outstanding reservations
    always_ff @(posedge Clock) begin
        if (Reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Read ports share one implementation, indexed 0 = S and 1 = T
    logic [NUM_PORTS-1:0][ADDR_W-1:0] port_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] port_data;
    logic [NUM_PORTS-1:0]             port_busy;

    assign port_addr[0] = RS;
    assign port_addr[1] = RT;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_read_port
            logic              addr_zero;
            logic [DATA_W-1:0] data_val;
            logic              busy_val;

            assign addr_zero = (ZERO_REG != 0) && (port_addr[p] == ZERO_ADDR);

            // Stored-state read with zero-register masking. Optional same-cycle forwarding.
            always_comb begin
                data_val = addr_zero ? '0   : regs[port_addr[p]];
                busy_val = addr_zero ? 1'b0 : busy[port_addr[p]];
`ifdef REGFILE_BYPASS_EN
                // write_ok already excludes address 0, so masking still holds
                if (!Reset && write_ok && (RD == port_addr[p])) begin
                    data_val = WriteData;
                    busy_val = reserve_ok && (RsvAddr == port_addr[p]);
                end
`else
                // Without forwarding, reads reflect stored state only
`endif
            end

            assign port_data[p] = data_val;
            assign port_busy[p] = busy_val;
        end
    endgenerate

    assign ReadRS = port_data[0];
    assign ReadRT = port_data[1];
    assign BusyRS = port_busy[0];
    assign BusyRT = port_busy[1];

endmodule
`default_nettype wire

// File: tb/tb_register_file_sb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_sb
//  Description : Scoreboard bench for register_file_sb. The driver pushes the
//                expected read-port values for every cycle it checks. A
//                separate monitor pops and compares them on the falling edge.
//                Honours REGFILE_BYPASS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_register_file_sb;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 2;
    localparam int ZERO_REG = 1;
    localparam int DEPTH    = 4;

    logic              Clock = 1'b0;
    logic              Reset = 1'b0;
    logic [ADDR_W-1:0] RS = '0;
    logic [ADDR_W-1:0] RT = '0;
    logic [DATA_W-1:0] ReadRS;
    logic [DATA_W-1:0] ReadRT;
    logic              BusyRS;
    logic              BusyRT;
    logic [ADDR_W-1:0] RD = '0;
    logic [DATA_W-1:0] WriteData = '0;
    logic              RegWrite = 1'b0;
    logic              Reserve = 1'b0;
    logic [ADDR_W-1:0] RsvAddr = '0;

    register_file_sb #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .RS        (RS),
        .RT        (RT),
        .ReadRS    (ReadRS),
        .ReadRT    (ReadRT),
        .BusyRS    (BusyRS),
        .BusyRT    (BusyRT),
        .RD        (RD),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .Reserve   (Reserve),
        .RsvAddr   (RsvAddr)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string             tag;
        logic [DATA_W-1:0] ds;
        logic [DATA_W-1:0] dt;
        logic              bs;
        logic              bt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: the register contents and the set of reserved registers
    logic [DATA_W-1:0] model_data [DEPTH];
    bit                model_busy [DEPTH];

    function automatic bit writable(input logic [ADDR_W-1:0] a);
        return (ZERO_REG == 0) || (a != 0);
    endfunction

    // Values a read of address a must show right now, given the driven inputs
    function automatic void predict(input logic [ADDR_W-1:0] a,
                                    output logic [DATA_W-1:0] d, output logic b);
        if (!writable(a)) begin
            d = '0;
            b = 1'b0;
        end else begin
            d = model_data[a];
            b = model_busy[a];
`ifdef REGFILE_BYPASS_EN
            if (!Reset && RegWrite && RD == a) begin
                d = WriteData;
                b = Reserve && RsvAddr == a;
            end
`endif
        end
    endfunction

    task automatic step(input string tag, input bit rst, input bit rw, input bit rsv,
                        input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
                        input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] ra,
                        input logic [DATA_W-1:0] wd, input bit chk);
        exp_t e;
        Reset     = rst;
        RegWrite  = rw;
        Reserve   = rsv;
        RS        = rs;
        RT        = rt;
        RD        = rd;
        RsvAddr   = ra;
        WriteData = wd;
        if (chk) begin
            e.tag = tag;
            predict(rs, e.ds, e.bs);
            predict(rt, e.dt, e.bt);
            sb.push_back(e);
        end
        @(posedge Clock);
        #1;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                model_data[i] = '0;
                model_busy[i] = 1'b0;
            end
        end else begin
            if (rw && writable(rd)) begin
                model_data[rd] = wd;
                model_busy[rd] = 1'b0;
            end
            if (rsv && writable(ra)) model_busy[ra] = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input string what,
                       input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s %s: got=%h want=%h (t=%0t)", tag, what, got, want, $time);
        end
    endtask

    // Monitor: outputs are valid every checked cycle; compare on the falling edge
    always @(negedge Clock) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, "ReadRS", ReadRS, e.ds);
            chk(e.tag, "ReadRT", ReadRT, e.dt);
            chk(e.tag, "BusyRS", {{(DATA_W-1){1'b0}}, BusyRS}, {{(DATA_W-1){1'b0}}, e.bs});
            chk(e.tag, "BusyRT", {{(DATA_W-1){1'b0}}, BusyRT}, {{(DATA_W-1){1'b0}}, e.bt});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model_data[i] = '0;
            model_busy[i] = 1'b0;
        end
        @(posedge Clock);
        #1;
        // 1: reset, then every address pair reads zero and not busy
        step("reset", 1, 0, 0, 0, 0, 0, 0, 16'h0, 0);
        for (int a = 0; a < DEPTH; a++)
            for (int b = 0; b < DEPTH; b++)
                step("reset_read", 0, 0, 0, a[1:0], b[1:0], 0, 0, 16'h0, 1);
        // 2: two writes, then read both
        step("wr3",  0, 1, 0, 0, 0, 3, 0, 16'd5, 1);
        step("wr2",  0, 1, 0, 0, 0, 2, 0, 16'd7, 1);
        step("rd32", 0, 0, 0, 3, 2, 0, 0, 16'h0, 1);
        // 3: reserve, then writeback clears the reservation
        step("rsv2",      0, 0, 1, 0, 2, 0, 2, 16'h0, 1);
        step("busy2",     0, 0, 0, 0, 2, 0, 0, 16'h0, 1);
        step("wb2",       0, 1, 0, 0, 2, 2, 0, 16'd9, 1);
        step("after_wb2", 0, 0, 0, 0, 2, 0, 0, 16'h0, 1);
        // 4: write and reserve the same register; writes to register 0 are dropped
        step("wr_rsv1",  0, 1, 1, 1, 0, 1, 1, 16'd4, 1);
        step("chk1",     0, 0, 0, 1, 1, 0, 0, 16'h0, 1);
        step("zero_req", 0, 1, 1, 0, 1, 0, 0, 16'hFFFF, 1);
        step("zero_chk", 0, 0, 0, 0, 0, 0, 0, 16'h0, 1);
        // 5: reset in the middle of activity discards data and reservations
        step("rsv_r1", 0, 0, 1, 1, 2, 0, 1, 16'h0, 1);
        step("rsv_r2", 0, 0, 1, 1, 2, 0, 2, 16'h0, 1);
        step("rsv_r3", 0, 0, 1, 3, 2, 0, 3, 16'h0, 1);
        step("wr3_aa", 0, 1, 0, 3, 1, 3, 0, 16'hAAAA, 1);
        step("mid_rst", 1, 1, 1, 3, 1, 1, 2, 16'h5555, 1);
        for (int a = 0; a < DEPTH; a++)
            step("post_rst", 0, 0, 0, a[1:0], a[1:0], 0, 0, 16'h0, 1);
        // 6: same-cycle visibility of a write
        step("bypass",       0, 1, 0, 1, 0, 1, 0, 16'h1234, 1);
        step("bypass_after", 0, 0, 0, 1, 1, 0, 0, 16'h0, 1);
        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step("random", ($urandom_range(0, 63) == 0), $urandom_range(0, 1),
                 $urandom_range(0, 1), 2'($urandom), 2'($urandom), 2'($urandom),
                 2'($urandom), 16'($urandom), 1);
        end
        step("idle", 0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge Clock);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got=%0d pending want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
